// File: rtl/slurm16_memory_arbiter.sv
// slurm16_memory_arbiter
// Four-master round-robin arbiter in front of a single-port synchronous RAM
// with one-cycle read latency. A master keeps the bus for at most MAX_BURST
// consecutive grants while another master is waiting.
//
// Optional build macro: SLURM16_ARB_CPU_PRIORITY_EN
//   When defined, master 0 (CPU) wins every cycle it is valid; masters 1-3
//   share the bus round-robin only while the CPU is idle.
//
// MAX_BURST must lie in 1..16.
module slurm16_memory_arbiter #(
    parameter int unsigned BITS         = 16,
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic                      CLK,
    input  logic                      RSTb,
    input  logic [4*ADDRESS_BITS-1:0] req_addr,
    input  logic [4*BITS-1:0]         req_wdata,
    input  logic [3:0]                req_valid,
    input  logic [3:0]                req_wr,
    output logic [3:0]                req_ready,
    output logic [BITS-1:0]           rdata,
    output logic [3:0]                rvalid,
    output logic [ADDRESS_BITS-1:0]   mem_addr,
    output logic [BITS-1:0]           mem_wdata,
    output logic                      mem_wr,
    input  logic [BITS-1:0]           mem_rdata
);

    localparam int unsigned       CntBits   = 5;
    localparam logic [CntBits-1:0] BurstLast = CntBits'(MAX_BURST - 1);

    logic [1:0]         owner_q, owner_d;
    logic [CntBits-1:0] burst_cnt_q, burst_cnt_d;
    logic [3:0]         rd_pending_q, rd_pending_d;

    logic               grant_any;
    logic               grant_en;
    logic [1:0]         grant_idx;
    logic [2:0]         scan;

    // First valid master strictly after 'from' in circular order; bit 2 = found.
    function automatic logic [2:0] next_valid(input logic [1:0] from, input logic [3:0] valid);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from the farthest candidate back so the nearest one wins.
        for (int k = 3; k >= 1; k--) begin
            idx = from + 2'(k);
            if (valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Grant selection and next owner / burst count.
    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = '0;
        grant_any   = 1'b0;
        grant_idx   = owner_q;
        scan        = next_valid(owner_q, req_valid);

        if (req_valid == 4'b0000) begin
            // Idle: keep owner, restart its burst window.
            grant_any = 1'b0;
        end else if (req_valid[owner_q]) begin
            grant_any = 1'b1;
            if (burst_cnt_q < BurstLast) begin
                grant_idx   = owner_q;
                burst_cnt_d = burst_cnt_q + CntBits'(1);
            end else if (scan[2]) begin
                // Burst exhausted and someone else is waiting: hand over.
                grant_idx = scan[1:0];
                owner_d   = scan[1:0];
            end else begin
                // Burst exhausted but alone: keep going, fresh window.
                grant_idx = owner_q;
            end
        end else begin
            // Owner not requesting; at least one other bit is set, so scan hits.
            grant_any = 1'b1;
            grant_idx = scan[1:0];
            owner_d   = scan[1:0];
        end

`ifdef SLURM16_ARB_CPU_PRIORITY_EN
        // CPU overrides whatever the round-robin picked.
        if (req_valid[0]) begin
            grant_any   = 1'b1;
            grant_idx   = 2'd0;
            owner_d     = 2'd0;
            burst_cnt_d = '0;
        end
`endif
    end

    // Grant decode and memory-side mux; nothing is granted while reset is asserted.
    always_comb begin
        grant_en  = grant_any & RSTb;
        req_ready = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        if (grant_en) begin
            req_ready = 4'b0001 << grant_idx;
            mem_addr  = req_addr[grant_idx*ADDRESS_BITS +: ADDRESS_BITS];
            mem_wdata = req_wdata[grant_idx*BITS +: BITS];
            mem_wr    = req_wr[grant_idx];
        end
        rd_pending_d = req_ready & ~req_wr;
    end

    // Arbitration state and one-cycle read-return tracking.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            owner_q      <= 2'd3;
            burst_cnt_q  <= '0;
            rd_pending_q <= 4'b0000;
        end else begin
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign rvalid = rd_pending_q;
    assign rdata  = mem_rdata;

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// Self-checking bench for slurm16_memory_arbiter: directed scenarios plus a
// randomized phase, checked by a queue-based scoreboard against a
// behavioural arbitration/memory model.
module tb_slurm16_memory_arbiter;

    localparam int MAXB = 4;

    logic        CLK;
    logic        RSTb;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_valid;
    logic [3:0]  req_wr;
    logic [3:0]  req_ready;
    logic [15:0] rdata;
    logic [3:0]  rvalid;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr;
    logic [15:0] mem_rdata;

    // Second instance with MAX_BURST = 1, sharing the request inputs.
    logic [3:0]  rr_ready;
    logic [15:0] rr_rdata;
    logic [3:0]  rr_rvalid;
    logic [15:0] rr_mem_addr;
    logic [15:0] rr_mem_wdata;
    logic        rr_mem_wr;

    slurm16_memory_arbiter #(.BITS(16), .ADDRESS_BITS(16), .MAX_BURST(MAXB)) u_dut (
        .CLK(CLK), .RSTb(RSTb), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_valid(req_valid), .req_wr(req_wr), .req_ready(req_ready), .rdata(rdata),
        .rvalid(rvalid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    slurm16_memory_arbiter #(.BITS(16), .ADDRESS_BITS(16), .MAX_BURST(1)) u_rr (
        .CLK(CLK), .RSTb(RSTb), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_valid(req_valid), .req_wr(req_wr), .req_ready(rr_ready), .rdata(rr_rdata),
        .rvalid(rr_rvalid), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_wr(rr_mem_wr), .mem_rdata(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A3C);
    endfunction

    // Synchronous single-port RAM, read-before-write, one-cycle latency.
    logic [15:0] ram [logic [15:0]];
    always @(posedge CLK) begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_val(mem_addr);
        if (mem_wr) ram[mem_addr] = mem_wdata;
    end

    typedef struct {
        logic [3:0]  ready;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } grant_t;

    typedef struct {
        int          due;
        int          m;
        logic [15:0] data;
    } rd_t;

    grant_t      exp_grant[$];
    rd_t         rd_q[$];
    logic [15:0] model_mem [logic [15:0]];
    int          m_owner = 3;
    int          m_held  = 1;   // grants given to m_owner in the current window
    int          last_g  = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick_after(input int from, input logic [3:0] v);
        for (int k = 1; k <= 3; k++) begin
            if (v[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    // Reference arbitration: returns granted master or -1.
    task automatic model_step(input logic [3:0] v, output int g);
        int nxt;
        g = -1;
`ifdef SLURM16_ARB_CPU_PRIORITY_EN
        if (v[0]) begin
            g = 0;
            m_owner = 0;
            m_held = 1;
        end else
`endif
        if (v == 4'b0000) begin
            m_held = 1;
        end else if (v[m_owner]) begin
            if (m_held < MAXB) begin
                g = m_owner;
                m_held++;
            end else begin
                nxt = pick_after(m_owner, v);
                if (nxt < 0) begin
                    g = m_owner;
                end else begin
                    g = nxt;
                    m_owner = nxt;
                end
                m_held = 1;
            end
        end else begin
            g = pick_after(m_owner, v);
            m_owner = g;
            m_held = 1;
        end
    endtask

    // Predict this cycle's grant and any read return, push to the scoreboard.
    task automatic issue();
        int g;
        grant_t e;
        rd_t r;
        logic [15:0] a;
        model_step(req_valid, g);
        last_g = g;
        e.ready = 4'b0000; e.wr = 1'b0; e.addr = 16'h0000; e.wdata = 16'h0000;
        if (g >= 0) begin
            a = req_addr[g*16 +: 16];
            e.ready = 4'b0001 << g;
            e.wr    = req_wr[g];
            e.addr  = a;
            e.wdata = req_wdata[g*16 +: 16];
            if (req_wr[g]) begin
                model_mem[a] = e.wdata;
            end else begin
                r.due  = cyc + 1;
                r.m    = g;
                r.data = model_mem.exists(a) ? model_mem[a] : init_val(a);
                rd_q.push_back(r);
            end
        end
        exp_grant.push_back(e);
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        req_valid[i]         = v;
        req_wr[i]            = w;
        req_addr[i*16 +: 16] = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    task automatic clear_all();
        req_valid = 4'b0000;
        req_wr    = 4'b0000;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic cycle_end();
        @(posedge CLK);
        #1;
    endtask

    // Entered and left at posedge+1; model and scoreboard restart with the DUT.
    task automatic do_reset();
        RSTb = 1'b0;
        clear_all();
        exp_grant.delete();
        rd_q.delete();
        m_owner = 3;
        m_held  = 1;
        repeat (2) @(posedge CLK);
        #1;
        RSTb = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents grant or read data.
    initial begin : monitor
        grant_t e;
        rd_t r;
        forever begin
            @(negedge CLK);
            if (RSTb) begin
                if (exp_grant.size() != 0) begin
                    e = exp_grant.pop_front();
                    chk("grant{ready,wr,addr,wdata}", {req_ready, mem_wr, mem_addr, mem_wdata},
                        {e.ready, e.wr, e.addr, e.wdata});
                end
                if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                    r = rd_q.pop_front();
                    chk("read_return{rvalid,rdata}", {rvalid, rdata}, {4'b0001 << r.m, r.data});
                end else begin
                    chk("no_stray_rvalid", {60'd0, rvalid}, 64'd0);
                end
            end
        end
    end

    int pat3 [12];
    int rr_pat [8];
    logic [3:0]  has;
    logic [15:0] r_addr [4];
    logic [15:0] r_data [4];
    logic        r_wr [4];

    initial begin : stim
`ifdef SLURM16_ARB_CPU_PRIORITY_EN
        pat3 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        pat3 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
`endif
        rr_pat = '{0, 1, 2, 3, 0, 1, 3, 0};

        // Reset state: requests present but nothing granted.
        RSTb = 1'b0;
        clear_all();
        req_valid = 4'b1111;
        #12;
        chk("reset_ready", {60'd0, req_ready}, 64'd0);
        chk("reset_rvalid_memwr", {59'd0, rvalid, mem_wr}, 64'd0);
        do_reset();

        // Master 0 read of 0x0010 straight after reset.
        set_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        issue();
        #1 chk("t1_grant{ready,wr,addr}", {req_ready, mem_wr, mem_addr}, {4'b0001, 1'b0, 16'h0010});
        cycle_end();

        // Master 2 write 0x1234 to 0x8000, then read it back.
        clear_all();
        set_req(2, 1'b1, 1'b1, 16'h8000, 16'h1234);
        issue();
        #1 chk("t1_rdata{rvalid,rdata}", {rvalid, rdata}, {4'b0001, 16'hBEEF});
        chk("t2_write{ready,wr,addr,wdata}", {req_ready, mem_wr, mem_addr, mem_wdata},
            {4'b0100, 1'b1, 16'h8000, 16'h1234});
        cycle_end();
        set_req(2, 1'b1, 1'b0, 16'h8000, 16'h0000);
        issue();
        #1 chk("t2_no_rvalid_for_write", {60'd0, rvalid}, 64'd0);
        chk("t2_read_grant", {60'd0, req_ready}, 64'h4);
        cycle_end();
        clear_all();
        issue();
        #1 chk("t2_rdata{rvalid,rdata}", {rvalid, rdata}, {4'b0100, 16'h1234});
        cycle_end();

        // Masters 0 and 1 continuously valid: bursts of MAXB.
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        set_req(1, 1'b1, 1'b0, 16'h0021, 16'h0000);
        for (int k = 0; k < 12; k++) begin
            issue();
            #1 chk("t3_burst_pattern", {60'd0, req_ready}, {60'd0, 4'b0001 << pat3[k]});
            cycle_end();
        end

        // Lone master 3 is never stalled by the burst limit.
        clear_all();
        set_req(3, 1'b1, 1'b0, 16'h0033, 16'h0000);
        for (int k = 0; k < 10; k++) begin
            issue();
            #1 chk("t4_lone_master", {60'd0, req_ready}, 64'h8);
            cycle_end();
        end

`ifndef SLURM16_ARB_CPU_PRIORITY_EN
        // MAX_BURST = 1 instance: pure rotation, dropped master skipped.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 16'h0040 + 16'(i), 16'h0000);
        for (int k = 0; k < 8; k++) begin
            if (k == 6) set_req(2, 1'b0, 1'b0, 16'h0042, 16'h0000);
            issue();
            #1 chk("t5_rr_order", {60'd0, rr_ready}, {60'd0, 4'b0001 << rr_pat[k]});
            cycle_end();
        end
`endif

        // Reset pulsed between a read grant and the next edge.
        clear_all();
        set_req(1, 1'b1, 1'b0, 16'h0055, 16'h0000);
        issue();
        @(negedge CLK);
        #2;
        RSTb = 1'b0;
        clear_all();
        #1 chk("t6_ready_in_reset", {60'd0, req_ready}, 64'd0);
        exp_grant.delete();
        rd_q.delete();
        m_owner = 3;
        m_held  = 1;
        #1 RSTb = 1'b1;
        cycle_end();
        chk("t6_rvalid_dropped", {60'd0, rvalid}, 64'd0);
        set_req(1, 1'b1, 1'b0, 16'h0061, 16'h0000);
        set_req(2, 1'b1, 1'b0, 16'h0062, 16'h0000);
        issue();
        #1 chk("t6_first_grant", {60'd0, req_ready}, 64'h2);
        cycle_end();

`ifdef SLURM16_ARB_CPU_PRIORITY_EN
        // CPU priority: master 0 wins until it drops valid.
        clear_all();
        set_req(0, 1'b1, 1'b0, 16'h0070, 16'h0000);
        set_req(1, 1'b1, 1'b0, 16'h0071, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            issue();
            #1 chk("t7_cpu_wins", {60'd0, req_ready}, 64'h1);
            cycle_end();
        end
        set_req(0, 1'b0, 1'b0, 16'h0070, 16'h0000);
        issue();
        #1 chk("t7_master1_after_cpu", {60'd0, req_ready}, 64'h2);
        cycle_end();
`endif

        // Randomized traffic with held requests and withdrawals.
        clear_all();
        has = 4'b0000;
        last_g = -1;
        for (int i = 0; i < 4; i++) begin
            r_addr[i] = 16'h0000; r_data[i] = 16'h0000; r_wr[i] = 1'b0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (last_g == i) has[i] = 1'b0;
                if (has[i] && $urandom_range(0, 9) == 0) begin
                    has[i] = 1'b0;
                end else if (!has[i] && $urandom_range(0, 2) != 0) begin
                    has[i]    = 1'b1;
                    r_addr[i] = ($urandom_range(0, 7) == 0) ? 16'h0010
                                                             : (16'h8000 | 16'($urandom_range(0, 31)));
                    r_data[i] = 16'($urandom);
                    r_wr[i]   = 1'($urandom_range(0, 1));
                end
                set_req(i, has[i], r_wr[i], r_addr[i], r_data[i]);
            end
            issue();
            cycle_end();
        end

        clear_all();
        repeat (3) begin
            issue();
            cycle_end();
        end
        chk("scoreboard_drained", 64'(rd_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/slurm16_memory_arbiter.md
Name: slurm16_memory_arbiter

Overview:
- Responder end of the SLURM16 memory request bus: accepts valid/wr/address/data requests from four masters and returns a per-master ready (grant) plus read data.
- Master 0 is the CPU memory interface. Masters 1-3 are DMA-style clients (gfx, audio, flash loader).
- Sits between the masters and a single-port synchronous RAM with one-cycle read latency.
- Round-robin arbitration with a bounded burst hold.

Parameters:
- BITS, 16, data word width.
- ADDRESS_BITS, 16, word address width.
- MAX_BURST, 4, maximum consecutive grants to one master while another is waiting; legal 1..16.

Ports:
- CLK  input  1  system clock.
- RSTb  input  1  asynchronous active-low reset.
- req_addr  input  4*ADDRESS_BITS  packed addresses; master i at [i*ADDRESS_BITS +: ADDRESS_BITS].
- req_wdata  input  4*BITS  packed write data; master i at [i*BITS +: BITS].
- req_valid  input  4  request present, per master.
- req_wr  input  4  1 = write, 0 = read, per master.
- req_ready  output  4  grant; the request is consumed in this cycle.
- rdata  output  BITS  read data, shared by all masters.
- rvalid  output  4  rdata belongs to master i this cycle.
- mem_addr  output  ADDRESS_BITS  RAM address.
- mem_wdata  output  BITS  RAM write data.
- mem_wr  output  1  RAM write enable.
- mem_rdata  input  BITS  RAM read data, valid one cycle after the address.

Behaviour:
- Clock and reset: one clock, CLK; reset RSTb is asynchronous, active-low.
- Registered state:
  - owner[1:0]: last granted master; reset 3, so master 0 is searched first.
  - burst_cnt: reset 0.
  - rd_pending[3:0]: reset 0.
- Grant selection is combinational from the registered state and req_valid, computed every cycle:
  - No req_valid bits set: no grant; owner unchanged; burst_cnt <= 0.
  - req_valid[owner] = 1 and burst_cnt < MAX_BURST-1: grant owner; burst_cnt++.
  - req_valid[owner] = 1, burst_cnt = MAX_BURST-1, and another master valid: grant the first valid master after owner in order owner+1, owner+2, owner+3 (mod 4); owner <= that master; burst_cnt <= 0.
  - req_valid[owner] = 1, burst_cnt = MAX_BURST-1, no other master valid: grant owner; burst_cnt <= 0.
  - req_valid[owner] = 0: grant the first valid master after owner (mod 4); owner <= that master; burst_cnt <= 0.
- req_ready is one-hot or zero. It is combinational and forced 0 while RSTb is low.
- Granted master g drives memory outputs combinationally:
  - mem_addr = req_addr[g];
  - mem_wdata = req_wdata[g];
  - mem_wr = req_wr[g].
- With no grant: mem_wr = 0, mem_addr = 0, mem_wdata = 0.
- Read return: rd_pending[g] <= granted & ~req_wr[g]. rvalid = rd_pending. rdata = mem_rdata as a pass-through. Read latency is exactly 1 cycle after req_ready.
- Write completion: a write completes in the req_ready cycle; no rvalid is produced.
- Masters hold addr/wdata/wr stable while valid is high and ready is low. A master may drop valid without being granted (request withdrawn); no side effect.
- Back-to-back reads from one master return on consecutive cycles.
- Reset mid-operation: all state returns to reset values. Any pending rvalid is dropped and is not re-issued.
- MAX_BURST = 1: pure round-robin whenever two or more masters are valid.

Optional Feature:
- Macro: SLURM16_ARB_CPU_PRIORITY_EN.
- Defined: master 0, when valid, is always granted regardless of owner or burst_cnt; owner <= 0 and burst_cnt <= 0 on each CPU grant. Masters 1-3 round-robin among themselves only when master 0 is idle; their burst rules are unchanged.
- Undefined: master 0 is arbitrated exactly like masters 1-3.

Test Plan:
- Reset release, master 0 read of addr 0x0010, RAM holds 0xBEEF: req_ready = 0001 same cycle, mem_addr = 0x0010, mem_wr = 0; next cycle rvalid = 0001, rdata = 0xBEEF.
- Master 2 writes 0x1234 to 0x8000, then master 2 reads 0x8000: write cycle shows mem_wr = 1, mem_wdata = 0x1234, no rvalid. Read returns 0x1234 with rvalid = 0100.
- Masters 0 and 1 valid continuously, MAX_BURST = 4: grant pattern is 0,0,0,0,1,1,1,1,0... Each master sees exactly 4 consecutive ready cycles.
- Only master 3 valid for 10 cycles: req_ready = 1000 on all 10 cycles. No other bits ever set; burst limit does not stall a lone master.
- All four masters valid, MAX_BURST = 1: grants cycle 0,1,2,3,0. Dropping master 2's valid mid-sequence skips it with no bubble cycle.
- Read issued, RSTb pulsed low before the next edge: rvalid = 0000 after reset; owner = 3; first post-reset grant goes to the lowest valid master.
- With SLURM16_ARB_CPU_PRIORITY_EN and masters 0 and 1 both valid: master 0 wins every cycle. Master 1 is granted only in the cycle after master 0 drops valid.
